// File: rtl/axi_sram_slave.sv
// AXI3 slave serving read/write bursts from one single-port synchronous SRAM.
// One transaction in flight; reads and writes alternate priority at address accept.
module axi_sram_slave #(
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid-side payload is held stable until that edge.
  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_CAP, S_RD_RESP, S_WR_DATA, S_WR_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;   // 1 = write side wins a tie
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        beat_q, beat_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              bvalid_q, bvalid_d;
  logic              last_beat;
  logic [31:0]       addr_next;
  logic              unused_wid;

  assign unused_wid = ^wid;
  assign last_beat  = (beat_q == len_q);
  assign addr_next  = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << size_q);

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prio_q   <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      bvalid_q <= bvalid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    size_d     = size_q;
    burst_d    = burst_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    rvalid_d   = rvalid_q;
    bvalid_d   = bvalid_q;
    // rst gating keeps the IDLE-derived readies low while reset is held
    arready    = (state_q == S_IDLE) && !rst && !(awvalid && prio_q);
    awready    = (state_q == S_IDLE) && !rst && !(arvalid && !prio_q);
    wready     = (state_q == S_WR_DATA);
    sram_en    = 1'b0;
    sram_wen   = 4'b0000;
    sram_addr  = addr_q[ADDR_W+1:2];
    sram_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (arvalid && arready) begin
          id_d    = arid;
          addr_d  = araddr;
          len_d   = arlen;
          size_d  = (arsize > 3'd2) ? 2'd2 : arsize[1:0];
          burst_d = arburst;
          beat_d  = '0;
          err_d   = 1'b0;
          prio_d  = 1'b1;
          state_d = S_RD_REQ;
        end else if (awvalid && awready) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen;
          size_d  = (awsize > 3'd2) ? 2'd2 : awsize[1:0];
          burst_d = awburst;
          beat_d  = '0;
          err_d   = 1'b0;
          prio_d  = 1'b0;
          state_d = S_WR_DATA;
        end
      end
      S_RD_REQ: begin
        sram_en = 1'b1;
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        rdata_d  = sram_rdata;
        rvalid_d = 1'b1;
        state_d  = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_next;
            state_d = S_RD_REQ;
          end
        end
      end
      S_WR_DATA: begin
        if (wvalid) begin
          sram_en    = 1'b1;
          sram_wen   = wstrb;
          sram_wdata = wdata;
          err_d      = err_q | (wlast != last_beat);
          if (last_beat) begin
            bvalid_d = 1'b1;
            state_d  = S_WR_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = addr_next;
          end
        end
      end
      S_WR_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign rid       = rvalid_q ? id_q : '0;
  assign rlast     = rvalid_q && last_beat;
  assign rresp     = 2'b00;
  assign bvalid    = bvalid_q;
  assign bid       = bvalid_q ? id_q : '0;
  assign bresp     = (bvalid_q && err_q) ? 2'b10 : 2'b00;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: tasks drive AR/AW/W, a monitor pops expected R/B beats
// computed from a word-array memory model and compares them.
module tb_axi_sram_slave;
  localparam int ADDR_W = 10;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int RW     = ID_W + 32 + 1;
  localparam int BW     = ID_W + 2;

  logic              aclk = 1'b0;
  logic              rst;
  logic [ID_W-1:0]   arid, awid, wid, rid, bid;
  logic [31:0]       araddr, awaddr, rdata, wdata, sram_wdata, sram_rdata;
  logic [7:0]        arlen, awlen;
  logic [2:0]        arsize, awsize, dbg_state;
  logic [1:0]        arburst, awburst, rresp, bresp;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]        wstrb, sram_wen;
  logic              sram_en;
  logic [ADDR_W-1:0] sram_addr;

  logic              manual_r, man_rready, rand_rready, preload;
  logic [31:0]       sram_mem [0:DEPTH-1];
  logic [31:0]       ref_mem  [0:DEPTH-1];
  logic [RW-1:0]     exp_r_q[$];
  logic [BW-1:0]     exp_b_q[$];
  int                errors = 0;
  int                checks = 0;

  assign rready = manual_r ? man_rready : rand_rready;

  axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .aclk(aclk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 32'h40) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // SRAM environment: 1-cycle read latency, byte write enables
  always @(posedge aclk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] <= init_word(i);
    end else if (sram_en) begin
      if (sram_wen == 4'b0000) sram_rdata <= sram_mem[sram_addr];
      else for (int j = 0; j < 4; j++)
        if (sram_wen[j]) sram_mem[sram_addr][8*j +: 8] <= sram_wdata[8*j +: 8];
    end
  end

  initial begin
    forever begin
      @(posedge aclk); #1;
      rand_rready = ($urandom_range(0, 3) != 0);
      bready      = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: actual=timeout required=handshake", nm);
  endtask

  // reference model: byte address of beat b, then word index within the SRAM
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] bu, input int b);
    int s;
    s = (sz > 3'd2) ? 2 : int'(sz);
    if (bu == 2'b00) return a;
    return a + (32'(b) << s);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  // driver tasks: called and return just after a rising edge (+1)
  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    bit hs = 0;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    for (int t = 0; t < 400 && !hs; t++) begin
      @(negedge aclk); hs = arready;
      @(posedge aclk); #1;
    end
    arvalid = 1'b0;
    if (!hs) begin timeout_fail("ar_handshake"); return; end
    for (int b = 0; b <= int'(len); b++)
      exp_r_q.push_back({id, ref_mem[widx(beat_addr(a, sz, bu, b))], b == int'(len)});
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu, input int bad_beat,
                          input bit fixed, input logic [31:0] fdata, input logic [3:0] fstrb);
    bit hs = 0;
    bit err = 0;
    int idx;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    for (int t = 0; t < 400 && !hs; t++) begin
      @(negedge aclk); hs = awready;
      @(posedge aclk); #1;
    end
    awvalid = 1'b0;
    if (!hs) begin timeout_fail("aw_handshake"); return; end
    for (int b = 0; b <= int'(len); b++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      wdata  = fixed ? fdata : $urandom();
      wstrb  = fixed ? fstrb : 4'($urandom_range(0, 15));
      wlast  = (b == int'(len)) ^ (b == bad_beat);
      wid    = 4'($urandom_range(0, 15));
      wvalid = 1'b1;
      hs = 0;
      for (int t = 0; t < 100 && !hs; t++) begin
        @(negedge aclk); hs = wready;
        @(posedge aclk); #1;
      end
      wvalid = 1'b0;
      if (!hs) begin timeout_fail("w_handshake"); return; end
      idx = widx(beat_addr(a, sz, bu, b));
      for (int j = 0; j < 4; j++)
        if (wstrb[j]) ref_mem[idx][8*j +: 8] = wdata[8*j +: 8];
      if (wlast != (b == int'(len))) err = 1;
    end
    wlast = 1'b0;
    exp_b_q.push_back({id, err ? 2'b10 : 2'b00});
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && (exp_r_q.size() != 0 || exp_b_q.size() != 0); t++) begin
      @(posedge aclk); #1;
    end
    if (exp_r_q.size() != 0 || exp_b_q.size() != 0) timeout_fail("drain");
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    exp_r_q.delete();
    exp_b_q.delete();
    repeat (2) @(posedge aclk);
    #1 rst = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    int cyc = 0;
    int last_evt = 0;
    bit pend = 0;
    bit exp_prio_w = 0;
    bit prev_rv = 0;
    bit prev_rr = 0;
    logic [RW-1:0] prev_pl = '0;
    logic [RW-1:0] e;
    logic [BW-1:0] eb;
    forever begin
      @(negedge aclk);
      cyc++;
      if (rst) begin
        prev_rv = 0; pend = 0; exp_prio_w = 0;
      end else begin
        if (rvalid && !prev_rv && pend) begin
          check("r_latency", 64'(cyc - last_evt), 64'd3);
          pend = 0;
        end
        if (prev_rv && !prev_rr) check("r_stable", {rvalid, rid, rdata, rlast}, {1'b1, prev_pl});
        if (arvalid && awvalid && (arready || awready))
          check("arb", {arready, awready}, {!exp_prio_w, exp_prio_w});
        if (arvalid && arready) begin exp_prio_w = 1; last_evt = cyc; pend = 1; end
        if (awvalid && awready) exp_prio_w = 0;
        if (rvalid && rready) begin
          if (exp_r_q.size() == 0) check("r_unexpected", {rid, rdata}, 64'd0 - 64'd1);
          else begin
            e = exp_r_q.pop_front();
            check("r_beat", {rid, rdata, rlast, rresp}, {e, 2'b00});
            if (!e[0]) begin last_evt = cyc; pend = 1; end
          end
        end
        if (bvalid && bready) begin
          if (exp_b_q.size() == 0) check("b_unexpected", {bid, bresp}, 64'd0 - 64'd1);
          else begin
            eb = exp_b_q.pop_front();
            check("b_resp", {bid, bresp}, eb);
          end
        end
        prev_rv = rvalid; prev_rr = rready; prev_pl = {rid, rdata, rlast};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    logic [7:0] len;
    arvalid = 0; awvalid = 0; wvalid = 0; wlast = 0; wdata = 0; wstrb = 0; wid = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    manual_r = 0; man_rready = 0; sram_rdata = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    rst = 1'b1; preload = 1'b1;
    repeat (2) @(posedge aclk);
    #1 preload = 1'b0;
    @(negedge aclk);
    check("reset_outputs", {arready, awready, wready, rvalid, bvalid, sram_en, sram_wen, rdata},
          64'd0);
    @(posedge aclk); #1 rst = 1'b0;
    @(negedge aclk);
    check("idle_ready", {arready, awready}, 2'b11);
    @(posedge aclk); #1;

    // single read of the preloaded word
    do_read(0, 32'h100, 0, 2, 2'b01);
    drain();
    // byte write into word 0x80, then read it back
    do_write(1, 32'h202, 0, 2, 2'b00, -1, 1, 32'h00AB0000, 4'b0100);
    drain();
    do_read(1, 32'h200, 0, 2, 2'b01);
    drain();

    // INCR burst with a 5-cycle rready stall on the second beat
    manual_r = 1; man_rready = 0;
    do_read(2, 32'h10, 3, 2, 2'b01);
    for (int b = 0; b < 4; b++) begin
      ok = 0;
      for (int t = 0; t < 50; t++) begin
        if (rvalid) begin ok = 1; break; end
        @(posedge aclk); #1;
      end
      if (!ok) timeout_fail("burst_rvalid");
      if (b == 1) repeat (5) begin @(posedge aclk); #1; end
      man_rready = 1;
      @(posedge aclk); #1 man_rready = 0;
    end
    manual_r = 0;
    drain();

    // collisions after reset: read wins first, then pending write beats the next read
    reset_dut();
    fork
      begin do_read(3, 32'h20, 1, 2, 2'b01); do_read(4, 32'h80, 1, 2, 2'b01); end
      do_write(5, 32'h80, 1, 2, 2'b01, -1, 0, 32'h0, 4'h0);
      begin @(negedge aclk); check("coll_read_first", {arready, awready}, 2'b10); end
    join
    drain();

    // wlast asserted early on a two-beat write
    do_write(6, 32'h300, 1, 2, 2'b01, 0, 0, 32'h0, 4'h0);
    drain();
    do_read(6, 32'h300, 1, 2, 2'b01);
    drain();

    // reset in the middle of a read burst
    manual_r = 1; man_rready = 0;
    do_read(7, 32'h40, 3, 2, 2'b01);
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      if (rvalid) begin ok = 1; break; end
      @(posedge aclk); #1;
    end
    if (!ok) timeout_fail("rst_burst_rvalid");
    rst = 1'b1;
    #1 check("rst_rvalid", rvalid, 1'b0);
    exp_r_q.delete();
    @(posedge aclk); #1 rst = 1'b0;
    @(negedge aclk);
    check("rst_arready", arready, 1'b1);
    manual_r = 0;
    repeat (20) @(posedge aclk);
    #1;

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      len = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1)
        do_read(4'($urandom_range(0, 15)), ($urandom() & 32'hFFFFF000) | 32'($urandom_range(0, 255)),
                len, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
      else
        do_write(4'($urandom_range(0, 15)), ($urandom() & 32'hFFFFF000) | 32'($urandom_range(0, 255)),
                 len, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                 ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(len)) : -1, 0, 32'h0, 4'h0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
